nios2system_onchip_memory_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single-port on-chip RAM (32-bit data, 15-bit word address, 22500 words, one-cycle read latency) between two Avalon-MM requesters: the Nios II data master and the DMA/streaming master. It accepts at most one transfer per cycle and drives the RAM's single port. It returns read data to the issuing master with a fixed one-cycle `readdatavalid` latency. Fairness is bounded: under contention, no master is served more than `MAX_BURST` consecutive transfers.

---
 rtl/nios2system_onchip_memory_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_nios2system_onchip_memory_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2system_onchip_memory_arbiter.sv
// nios2system_onchip_memory_arbiter
//
// Round-robin arbiter sharing one single-port on-chip RAM between two
// Avalon-MM requesters (s0 = Nios II data master, s1 = DMA/streaming master).
// At most one transfer is accepted per cycle. The grant is combinational, so an
// uncontended request is accepted in the cycle it is raised. Read data returns
// to the issuing master exactly one cycle after the accept.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   sN_read/sN_write     request strobes (held until accepted)
//   sN_address/_byteenable/_writedata  request fields
//   sN_waitrequest       high = not accepted this cycle
//   sN_readdata/_readdatavalid          read response
//   mem_*                RAM port (chipselect, write, address, byteenable,
//                        writedata, clken out; readdata in, 1-cycle latency)
module nios2system_onchip_memory_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int DEPTH     = 22500,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    // Per-master views of the request ports
    logic [1:0]        rd;
    logic [1:0]        wr;
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr  [2];
    logic [BE_W-1:0]   be    [2];
    logic [DATA_W-1:0] wdata [2];

    assign rd       = {s1_read, s0_read};
    assign wr       = {s1_write, s0_write};
    assign req      = rd | wr;
    assign addr[0]  = s0_address;
    assign addr[1]  = s1_address;
    assign be[0]    = s0_byteenable;
    assign be[1]    = s1_byteenable;
    assign wdata[0] = s0_writedata;
    assign wdata[1] = s1_writedata;

    // Arbitration state and pending-read register
    logic             pri_reg, pri_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pend_v_reg, pend_v_next;
    logic             pend_id_reg, pend_id_next;
    logic             pend_oor_reg, pend_oor_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [BE_W-1:0]   be_reg;
    logic [DATA_W-1:0] wdata_reg;

    // Same-cycle grant; nothing is granted while reset is asserted.
    logic gnt_valid;
    logic gnt_id;
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = pri_reg;
        if (!reset) begin
            if (req[0] && req[1]) begin
                gnt_valid = 1'b1;
                gnt_id    = pri_reg;
            end else if (req[0]) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req[1]) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // A simultaneous read+write strobe is treated as a write.
    logic              gnt_wr;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oor;
    assign gnt_wr   = wr[gnt_id];
    assign gnt_addr = addr[gnt_id];
    assign gnt_oor  = {1'b0, gnt_addr} >= DEPTH_EXT;

    // RAM port: fields hold their last granted value while idle.
    assign mem_address    = gnt_valid ? gnt_addr      : addr_reg;
    assign mem_byteenable = gnt_valid ? be[gnt_id]    : be_reg;
    assign mem_writedata  = gnt_valid ? wdata[gnt_id] : wdata_reg;
    assign mem_chipselect = gnt_valid && !gnt_oor;
    assign mem_write      = mem_chipselect && gnt_wr;
    assign mem_clken      = !reset;

    // Priority/burst bookkeeping and pending-read capture
    always_comb begin
        pri_next      = pri_reg;
        cnt_next      = cnt_reg;
        pend_v_next   = gnt_valid && !gnt_wr;
        pend_id_next  = gnt_id;
        pend_oor_next = gnt_oor;
        if (gnt_valid) begin
            if (gnt_id == pri_reg) begin
                if (cnt_reg == CNT_W'(MAX_BURST - 1)) begin
                    pri_next = !pri_reg;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else if (MAX_BURST == 1) begin
                // The new owner has already used its whole burst.
                pri_next = !gnt_id;
                cnt_next = '0;
            end else begin
                pri_next = gnt_id;
                cnt_next = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_reg      <= 1'b0;
            cnt_reg      <= '0;
            pend_v_reg   <= 1'b0;
            pend_id_reg  <= 1'b0;
            pend_oor_reg <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
        end else begin
            pri_reg      <= pri_next;
            cnt_reg      <= cnt_next;
            pend_v_reg   <= pend_v_next;
            pend_id_reg  <= pend_id_next;
            pend_oor_reg <= pend_oor_next;
            if (gnt_valid) begin
                addr_reg  <= gnt_addr;
                be_reg    <= be[gnt_id];
                wdata_reg <= wdata[gnt_id];
            end
        end
    end

    // Read response: gated by reset so a read accepted just before reset
    // asserts never reports valid data.
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    assign rsp_valid = pend_v_reg && !reset;
    assign rsp_data  = pend_oor_reg ? '0 : mem_readdata;

    logic [1:0]        wait_vec;
    logic [1:0]        rdv_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign wait_vec[gi]  = !(gnt_valid && (gnt_id == 1'(gi)));
            assign rdv_vec[gi]   = rsp_valid && (pend_id_reg == 1'(gi));
            assign rdata_vec[gi] = rdv_vec[gi] ? rsp_data : '0;

            a_no_rd_and_wr : assert property (@(posedge clk) disable iff (reset)
                !(rd[gi] && wr[gi]));
        end
    endgenerate

    assign s0_waitrequest   = wait_vec[0];
    assign s1_waitrequest   = wait_vec[1];
    assign s0_readdatavalid = rdv_vec[0];
    assign s1_readdatavalid = rdv_vec[1];
    assign s0_readdata      = rdata_vec[0];
    assign s1_readdata      = rdata_vec[1];

endmodule

// File: tb/tb_nios2system_onchip_memory_arbiter.sv
// Testbench for nios2system_onchip_memory_arbiter: directed scenarios plus a
// randomized run checked against a behavioural arbiter/RAM model.
module tb_nios2system_onchip_memory_arbiter;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int DEPTH     = 22500;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
    logic [ADDR_W-1:0] s0_address = '0, s1_address = '0;
    logic [BE_W-1:0]   s0_byteenable = '0, s1_byteenable = '0;
    logic [DATA_W-1:0] s0_writedata = '0, s1_writedata = '0;
    logic              s0_waitrequest, s1_waitrequest;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic              s0_readdatavalid, s1_readdatavalid;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;

    int checks = 0;
    int errors = 0;

    nios2system_onchip_memory_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
        .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Single-port RAM with one-cycle read latency. Port signals are captured
    // at the negative edge so the posedge update cannot race the arbiter.
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic              cap_cs = 0, cap_wr = 0, cap_clken = 0;
    logic [ADDR_W-1:0] cap_addr = '0;
    logic [BE_W-1:0]   cap_be = '0;
    logic [DATA_W-1:0] cap_wd = '0;

    always @(negedge clk) begin
        cap_cs    = mem_chipselect;
        cap_wr    = mem_write;
        cap_clken = mem_clken;
        cap_addr  = mem_address;
        cap_be    = mem_byteenable;
        cap_wd    = mem_writedata;
    end

    always @(posedge clk) begin
        if (cap_clken === 1'b1 && cap_cs === 1'b1) begin
            if (cap_wr === 1'b1) begin
                if (int'(cap_addr) < DEPTH)
                    for (int b = 0; b < BE_W; b++)
                        if (cap_be[b]) ram[cap_addr][8*b +: 8] = cap_wd[8*b +: 8];
            end else begin
                mem_readdata = (int'(cap_addr) < DEPTH) ? ram[cap_addr] : 32'hBAD0_BAD0;
            end
        end
    end

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        return 32'hA5A5_0000 ^ (v * 32'h9E37_79B1);
    endfunction

    // Expected RAM contents for the region used by the randomized run.
    logic [31:0] ref_mem [0:127];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    endtask

    task automatic set_req(input int m, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                           input logic [DATA_W-1:0] wd);
        if (m == 0) begin
            s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = wd;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = wd;
        end
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        set_req(0, 1, 0, 15'h10, 4'hF, 0);
        set_req(1, 1, 0, 15'h30, 4'hF, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b1) begin errors++;
                $display("FAIL rst_wait got s0=%b s1=%b want 1/1", s0_waitrequest, s1_waitrequest); end
            checks++; if (s0_readdatavalid !== 1'b0 || s1_readdatavalid !== 1'b0) begin errors++;
                $display("FAIL rst_rdv got s0=%b s1=%b want 0/0", s0_readdatavalid, s1_readdatavalid); end
            checks++; if (s0_readdata !== 0 || s1_readdata !== 0) begin errors++;
                $display("FAIL rst_rdata got s0=%h s1=%h want 0", s0_readdata, s1_readdata); end
            checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin errors++;
                $display("FAIL rst_mem got cs=%b wr=%b clken=%b want 000", mem_chipselect, mem_write, mem_clken); end
            tick();
        end
        reset = 0;
        @(negedge clk);
        checks++; if (s0_waitrequest !== 1'b0 || s1_waitrequest !== 1'b1) begin errors++;
            $display("FAIL post_rst_grant got s0=%b s1=%b want 0/1", s0_waitrequest, s1_waitrequest); end
        checks++; if (mem_clken !== 1'b1 || mem_chipselect !== 1'b1) begin errors++;
            $display("FAIL post_rst_mem got clken=%b cs=%b want 1/1", mem_clken, mem_chipselect); end
        tick();
        set_req(0, 0, 0, 15'h10, 4'hF, 0);
        @(negedge clk);
        checks++; if (s1_waitrequest !== 1'b0) begin errors++;
            $display("FAIL post_rst_s1 got wait=%b want 0", s1_waitrequest); end
        checks++; if (s0_readdatavalid !== 1'b1 || s0_readdata !== init_word(16)) begin errors++;
            $display("FAIL post_rst_rsp0 got v=%b d=%h want 1 %h", s0_readdatavalid, s0_readdata, init_word(16)); end
        tick();
        idle_all();
        @(negedge clk);
        checks++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== init_word(48) || s0_readdatavalid !== 1'b0) begin errors++;
            $display("FAIL post_rst_rsp1 got v=%b d=%h s0v=%b want 1 %h 0", s1_readdatavalid, s1_readdata, s0_readdatavalid, init_word(48)); end
        tick();
    endtask

    task automatic test_single();
        set_req(0, 0, 1, 15'h10, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        checks++; if (s0_waitrequest !== 1'b0 || s1_waitrequest !== 1'b1) begin errors++;
            $display("FAIL single_wr_wait got s0=%b s1=%b want 0/1", s0_waitrequest, s1_waitrequest); end
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 15'h10) begin errors++;
            $display("FAIL single_wr_mem got cs=%b wr=%b a=%h want 1 1 0010", mem_chipselect, mem_write, mem_address); end
        tick();
        set_req(0, 1, 0, 15'h10, 4'hF, 0);
        @(negedge clk);
        checks++; if (s0_waitrequest !== 1'b0 || mem_write !== 1'b0 || s0_readdatavalid !== 1'b0) begin errors++;
            $display("FAIL single_rd got wait=%b wr=%b rdv=%b want 0 0 0", s0_waitrequest, mem_write, s0_readdatavalid); end
        tick();
        idle_all();
        @(negedge clk);
        checks++; if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL single_rsp got v=%b d=%h want 1 cafef00d", s0_readdatavalid, s0_readdata); end
        checks++; if (s1_readdatavalid !== 1'b0 || s1_readdata !== 0 || s1_waitrequest !== 1'b1) begin errors++;
            $display("FAIL single_s1_quiet got v=%b d=%h w=%b want 0 0 1", s1_readdatavalid, s1_readdata, s1_waitrequest); end
        tick();
    endtask

    task automatic test_contention();
        int k[2];
        int exp_id, prev_id, prev_addr, nrsp[2];
        k[0] = 0; k[1] = 0; nrsp[0] = 0; nrsp[1] = 0; prev_id = -1; prev_addr = 0;
        do_reset();
        for (int cyc = 0; cyc <= 24; cyc++) begin
            for (int m = 0; m < 2; m++)
                set_req(m, k[m] < 12, 0, 15'(256 * (m + 1) + k[m]), 4'hF, 0);
            exp_id = (cyc < 24) ? (cyc / MAX_BURST) % 2 : -1;
            @(negedge clk);
            checks++; if (s0_waitrequest !== (exp_id != 0) || s1_waitrequest !== (exp_id != 1)) begin errors++;
                $display("FAIL contention_grant cyc=%0d got w0=%b w1=%b want master %0d", cyc, s0_waitrequest, s1_waitrequest, exp_id); end
            if (s0_readdatavalid === 1'b1) nrsp[0]++;
            if (s1_readdatavalid === 1'b1) nrsp[1]++;
            if (prev_id >= 0) begin
                checks++;
                if ((prev_id == 0 && (s0_readdatavalid !== 1'b1 || s1_readdatavalid !== 1'b0 || s0_readdata !== init_word(prev_addr))) ||
                    (prev_id == 1 && (s1_readdatavalid !== 1'b1 || s0_readdatavalid !== 1'b0 || s1_readdata !== init_word(prev_addr)))) begin
                    errors++;
                    $display("FAIL contention_rsp cyc=%0d got v0=%b d0=%h v1=%b d1=%h want m%0d %h", cyc,
                             s0_readdatavalid, s0_readdata, s1_readdatavalid, s1_readdata, prev_id, init_word(prev_addr));
                end
            end
            prev_id = exp_id;
            if (exp_id >= 0) begin
                prev_addr = 256 * (exp_id + 1) + k[exp_id];
                k[exp_id]++;
            end
            tick();
        end
        idle_all();
        checks++; if (nrsp[0] != 12 || nrsp[1] != 12) begin errors++;
            $display("FAIL contention_count got %0d/%0d want 12/12", nrsp[0], nrsp[1]); end
    endtask

    task automatic test_byteenable();
        set_req(0, 0, 1, 15'h20, 4'hF, 32'hFFFF_FFFF);
        tick();
        set_req(0, 0, 1, 15'h20, 4'h5, 32'h0000_0000);
        tick();
        set_req(0, 1, 0, 15'h20, 4'hF, 0);
        @(negedge clk);
        checks++; if (s0_waitrequest !== 1'b0) begin errors++;
            $display("FAIL be_rd_wait got %b want 0", s0_waitrequest); end
        tick();
        idle_all();
        @(negedge clk);
        checks++; if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'hFF00_FF00) begin errors++;
            $display("FAIL be_rsp got v=%b d=%h want 1 ff00ff00", s0_readdatavalid, s0_readdata); end
        tick();
    endtask

    task automatic test_oor();
        set_req(1, 0, 1, 15'(DEPTH), 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (s1_waitrequest !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin errors++;
            $display("FAIL oor_wr got w=%b cs=%b wr=%b want 0 0 0", s1_waitrequest, mem_chipselect, mem_write); end
        tick();
        set_req(1, 1, 0, 15'(DEPTH), 4'hF, 0);
        @(negedge clk);
        checks++; if (s1_waitrequest !== 1'b0 || mem_chipselect !== 1'b0) begin errors++;
            $display("FAIL oor_rd1 got w=%b cs=%b want 0 0", s1_waitrequest, mem_chipselect); end
        tick();
        set_req(1, 1, 0, 15'h7FFF, 4'hF, 0);
        @(negedge clk);
        checks++; if (mem_chipselect !== 1'b0 || s1_readdatavalid !== 1'b1 || s1_readdata !== 0) begin errors++;
            $display("FAIL oor_rd2 got cs=%b v=%b d=%h want 0 1 0", mem_chipselect, s1_readdatavalid, s1_readdata); end
        tick();
        idle_all();
        @(negedge clk);
        checks++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 0) begin errors++;
            $display("FAIL oor_rsp2 got v=%b d=%h want 1 0", s1_readdatavalid, s1_readdata); end
        checks++; if (ram[0] !== init_word(0)) begin errors++;
            $display("FAIL oor_word0 got %h want %h", ram[0], init_word(0)); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Four lone s0 reads: the fourth exhausts the burst, so without the
        // reset s1 would be preferred next.
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 0, 15'(64 + i), 4'hF, 0);
            tick();
        end
        reset = 1;
        set_req(0, 1, 0, 15'h50, 4'hF, 0);
        set_req(1, 1, 0, 15'h51, 4'hF, 0);
        @(negedge clk);
        checks++; if (s0_readdatavalid !== 1'b0) begin errors++;
            $display("FAIL midrst_rdv got %b want 0", s0_readdatavalid); end
        checks++; if (s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b1) begin errors++;
            $display("FAIL midrst_wait got s0=%b s1=%b want 1/1", s0_waitrequest, s1_waitrequest); end
        tick();
        reset = 0;
        @(negedge clk);
        checks++; if (s0_waitrequest !== 1'b0 || s1_waitrequest !== 1'b1) begin errors++;
            $display("FAIL midrst_pri got s0=%b s1=%b want 0/1", s0_waitrequest, s1_waitrequest); end
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_idle_priority();
        logic [5:0] order;
        int exp_id;
        order = 6'b111100;  // bit i = expected master on contended cycle i
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_req(0, 1, 0, 15'(80 + i), 4'hF, 0);
            set_req(1, 1, 0, 15'(90 + i), 4'hF, 0);
            @(negedge clk);
            checks++; if (s0_waitrequest !== 1'b0 || s1_waitrequest !== 1'b1) begin errors++;
                $display("FAIL idle_pre%0d got s0=%b s1=%b want 0/1", i, s0_waitrequest, s1_waitrequest); end
            tick();
        end
        idle_all();
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1, 0, 15'(82 + i), 4'hF, 0);
            set_req(1, 1, 0, 15'(92 + i), 4'hF, 0);
            exp_id = int'(order[i]);
            @(negedge clk);
            checks++; if (s0_waitrequest !== (exp_id != 0) || s1_waitrequest !== (exp_id != 1)) begin errors++;
                $display("FAIL idle_post%0d got s0=%b s1=%b want master %0d", i, s0_waitrequest, s1_waitrequest, exp_id); end
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_random();
        bit          p_v[2], p_wr[2];
        logic [14:0] p_addr[2];
        logic [3:0]  p_be[2];
        logic [31:0] p_wd[2];
        bit          r_v;
        int          r_id, g, owner, streak;
        logic [31:0] r_data;
        bit          inr;
        do_reset();
        owner = 0; streak = 0; r_v = 0; r_id = 0; r_data = 0;
        p_v[0] = 0; p_v[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p_v[m] && $urandom_range(0, 9) < 6) begin
                    p_v[m]    = 1;
                    p_wr[m]   = 1'($urandom_range(0, 1));
                    p_addr[m] = ($urandom_range(0, 7) == 0) ?
                                15'(DEPTH + int'($urandom_range(0, 32767 - DEPTH))) :
                                15'(64 + int'($urandom_range(0, 63)));
                    p_be[m]   = 4'($urandom);
                    p_wd[m]   = $urandom;
                end
                set_req(m, p_v[m] && !p_wr[m], p_v[m] && p_wr[m], p_addr[m], p_be[m], p_wd[m]);
            end
            if (p_v[0] && p_v[1]) g = owner;
            else if (p_v[0])      g = 0;
            else if (p_v[1])      g = 1;
            else                  g = -1;
            @(negedge clk);
            checks++; if (s0_waitrequest !== (g != 0) || s1_waitrequest !== (g != 1)) begin errors++;
                $display("FAIL rand_grant cyc=%0d got w0=%b w1=%b want master %0d", cyc, s0_waitrequest, s1_waitrequest, g); end
            checks++;
            if (s0_readdatavalid !== (r_v && r_id == 0) || s1_readdatavalid !== (r_v && r_id == 1) ||
                s0_readdata !== ((r_v && r_id == 0) ? r_data : 32'h0) ||
                s1_readdata !== ((r_v && r_id == 1) ? r_data : 32'h0)) begin
                errors++;
                $display("FAIL rand_rsp cyc=%0d got v0=%b d0=%h v1=%b d1=%h want v=%b m%0d %h", cyc,
                         s0_readdatavalid, s0_readdata, s1_readdatavalid, s1_readdata, r_v, r_id, r_data);
            end
            r_v = 0;
            if (g >= 0) begin
                inr = int'(p_addr[g]) < DEPTH;
                checks++;
                if (mem_chipselect !== inr || mem_write !== (inr && p_wr[g]) ||
                    (inr && mem_address !== p_addr[g])) begin
                    errors++;
                    $display("FAIL rand_mem cyc=%0d got cs=%b wr=%b a=%h want %b %b %h", cyc,
                             mem_chipselect, mem_write, mem_address, inr, inr && p_wr[g], p_addr[g]);
                end
                $display("txn cyc=%0d m%0d %s addr=%h be=%h wd=%h", cyc, g, p_wr[g] ? "WR" : "RD",
                         p_addr[g], p_be[g], p_wd[g]);
                if (p_wr[g]) begin
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (p_be[g][b]) ref_mem[p_addr[g]][8*b +: 8] = p_wd[g][8*b +: 8];
                end else begin
                    r_v = 1; r_id = g;
                    r_data = inr ? ref_mem[p_addr[g]] : 32'h0;
                end
                p_v[g] = 0;
                if (g == owner) streak++;
                else begin owner = g; streak = 1; end
                if (streak == MAX_BURST) begin owner = 1 - owner; streak = 0; end
            end
            tick();
        end
        idle_all();
        tick();
        for (int a = 64; a < 128; a++) begin
            checks++; if (ram[a] !== ref_mem[a]) begin errors++;
                $display("FAIL rand_ram a=%0d got %h want %h", a, ram[a], ref_mem[a]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_single();
        test_contention();
        test_byteenable();
        test_oor();
        test_reset_mid();
        test_idle_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
